// File: rtl/pll_lock_pkg.sv
// Shared types for the PLL lock conduit: lock FSM states and counter sizing helper.
package pll_lock_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    FILTER    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } lock_state_t;

  // Width able to hold the larger of the two window lengths without wrapping.
  function automatic int unsigned lock_cnt_width(input int unsigned filter_cycles,
                                                 input int unsigned hold_cycles);
    int unsigned max_cycles;
    max_cycles = (filter_cycles > hold_cycles) ? filter_cycles : hold_cycles;
    return $clog2(max_cycles + 1);
  endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-stage bit synchronizer with asynchronous active-high clear.
module pll_lock_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_reset_gen.sv
// Qualifies the asynchronous PLL lock and generates a synchronously released reset,
// with sticky loss-of-lock status and a saturating loss counter.
module pll_lock_reset_gen
  import pll_lock_pkg::*;
#(
  parameter int unsigned SYNC_STAGES        = 2,
  parameter int unsigned LOCK_FILTER_CYCLES = 16,
  parameter int unsigned RESET_HOLD_CYCLES  = 32,
  parameter int unsigned CNT_WIDTH          = 8
) (
  input  logic                 CLOCK,
  input  logic                 RESET,
  input  logic                 PLL_LOCKED,
  input  logic                 CLEAR_STATUS,
  output logic                 LOCKED,
  output logic                 RESET_N,
  output logic                 RESET_OUT,
  output logic                 LOCK_LOST,
  output logic [CNT_WIDTH-1:0] LOSS_COUNT
);

  localparam int unsigned CntW = lock_cnt_width(LOCK_FILTER_CYCLES, RESET_HOLD_CYCLES);
  localparam logic [CntW-1:0] FilterLast = CntW'(LOCK_FILTER_CYCLES - 1);
  localparam logic [CntW-1:0] HoldLast   = CntW'(RESET_HOLD_CYCLES - 1);

  logic lock_s;

  lock_state_t          state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 locked_q, locked_d;
  logic                 reset_n_q, reset_n_d;
  logic                 reset_out_q, reset_out_d;
  logic                 lock_lost_q, lock_lost_d;
  logic [CNT_WIDTH-1:0] loss_count_q, loss_count_d;
  logic                 loss_event;

  pll_lock_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_i (CLOCK),
    .rst_i (RESET),
    .d_i   (PLL_LOCKED),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    loss_event = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        if (lock_s) begin
          state_d = FILTER;
          cnt_d   = '0;
        end
      end
      FILTER: begin
        // A drop before qualification is just noise, not a loss event.
        if (!lock_s) begin
          state_d = WAIT_LOCK;
        end else if (cnt_q == FilterLast) begin
          state_d = HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      HOLD: begin
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          loss_event = 1'b1;
        end else if (cnt_q == HoldLast) begin
          state_d = RUN;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      RUN: begin
        if (!lock_s) begin
          state_d    = WAIT_LOCK;
          loss_event = 1'b1;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
  end

  // Clear is applied first so a coincident loss event still lands in the status.
  always_comb begin
    lock_lost_d  = lock_lost_q;
    loss_count_d = loss_count_q;
    if (CLEAR_STATUS) begin
      lock_lost_d  = 1'b0;
      loss_count_d = '0;
    end
    if (loss_event) begin
      lock_lost_d = 1'b1;
      if (loss_count_d != {CNT_WIDTH{1'b1}}) begin
        loss_count_d = loss_count_d + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    locked_d    = (state_d == HOLD) || (state_d == RUN);
    reset_n_d   = (state_d == RUN);
    reset_out_d = (state_d != RUN);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      locked_q     <= 1'b0;
      reset_n_q    <= 1'b0;
      reset_out_q  <= 1'b1;
      lock_lost_q  <= 1'b0;
      loss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      locked_q     <= locked_d;
      reset_n_q    <= reset_n_d;
      reset_out_q  <= reset_out_d;
      lock_lost_q  <= lock_lost_d;
      loss_count_q <= loss_count_d;
    end
  end

  assign LOCKED     = locked_q;
  assign RESET_N    = reset_n_q;
  assign RESET_OUT  = reset_out_q;
  assign LOCK_LOST  = lock_lost_q;
  assign LOSS_COUNT = loss_count_q;

endmodule

// File: tb/tb_pll_lock_reset_gen.sv
// Bench for pll_lock_reset_gen: directed scenarios plus randomized lock traffic,
// checked each cycle against a run-length model of the qualification rules.
module tb_pll_lock_reset_gen;

  localparam int unsigned SYNC    = 2;
  localparam int unsigned LF      = 16;
  localparam int unsigned RH      = 32;
  localparam int unsigned LOCK_AT = 1 + LF;       // consecutive lock samples to qualify
  localparam int unsigned RUN_AT  = 1 + LF + RH;  // consecutive lock samples to release
  localparam int unsigned MAX8    = 255;
  localparam int unsigned MAX2    = 3;

  logic       clock;
  logic       rst;
  logic       pll_locked;
  logic       clear_status;
  logic       locked, reset_n, reset_out, lock_lost;
  logic [7:0] loss_count;
  logic       locked2, reset_n2, reset_out2, lock_lost2;
  logic [1:0] loss_count2;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Model state: sampled PLL history, consecutive-lock run length, status.
  bit          sh[SYNC];
  int unsigned run;
  bit          m_lost;
  int unsigned m_cnt8, m_cnt2;

  pll_lock_reset_gen #(
    .SYNC_STAGES        (SYNC),
    .LOCK_FILTER_CYCLES (LF),
    .RESET_HOLD_CYCLES  (RH),
    .CNT_WIDTH          (8)
  ) dut (
    .CLOCK        (clock),
    .RESET        (rst),
    .PLL_LOCKED   (pll_locked),
    .CLEAR_STATUS (clear_status),
    .LOCKED       (locked),
    .RESET_N      (reset_n),
    .RESET_OUT    (reset_out),
    .LOCK_LOST    (lock_lost),
    .LOSS_COUNT   (loss_count)
  );

  pll_lock_reset_gen #(
    .SYNC_STAGES        (SYNC),
    .LOCK_FILTER_CYCLES (LF),
    .RESET_HOLD_CYCLES  (RH),
    .CNT_WIDTH          (2)
  ) dut_sat (
    .CLOCK        (clock),
    .RESET        (rst),
    .PLL_LOCKED   (pll_locked),
    .CLEAR_STATUS (clear_status),
    .LOCKED       (locked2),
    .RESET_N      (reset_n2),
    .RESET_OUT    (reset_out2),
    .LOCK_LOST    (lock_lost2),
    .LOSS_COUNT   (loss_count2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < SYNC; i++) sh[i] = 1'b0;
    run    = 0;
    m_lost = 1'b0;
    m_cnt8 = 0;
    m_cnt2 = 0;
  endtask

  task automatic model_edge(input bit pll, input bit clr);
    bit ls;
    bit loss;
    ls   = sh[SYNC-1];
    loss = !ls && (run >= LOCK_AT);
    run  = ls ? ((run < RUN_AT) ? run + 1 : run) : 0;
    for (int i = SYNC - 1; i > 0; i--) sh[i] = sh[i-1];
    sh[0] = pll;
    if (clr) begin
      m_lost = 1'b0;
      m_cnt8 = 0;
      m_cnt2 = 0;
    end
    if (loss) begin
      m_lost = 1'b1;
      if (m_cnt8 < MAX8) m_cnt8++;
      if (m_cnt2 < MAX2) m_cnt2++;
    end
  endtask

  task automatic compare_all(input string tag);
    bit e_locked, e_run;
    e_locked = (run >= LOCK_AT);
    e_run    = (run >= RUN_AT);
    check_eq({tag, ".locked"},     locked,      e_locked);
    check_eq({tag, ".reset_n"},    reset_n,     e_run);
    check_eq({tag, ".reset_out"},  reset_out,   !e_run);
    check_eq({tag, ".lock_lost"},  lock_lost,   m_lost);
    check_eq({tag, ".loss_count"}, loss_count,  m_cnt8);
    check_eq({tag, ".lost_sat"},   lock_lost2,  m_lost);
    check_eq({tag, ".count_sat"},  loss_count2, m_cnt2);
  endtask

  task automatic tick();
    @(posedge clock);
    model_edge(pll_locked, clear_status);
    #1;
    compare_all("cyc");
  endtask

  // Asserts RESET between edges and checks outputs before any clock edge occurs.
  task automatic do_reset();
    #1;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("async_rst");
    #1;
    rst = 1'b0;
  endtask

  task automatic ticks(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) tick();
  endtask

  // Expects PLL_LOCKED to have just risen; records first edges of LOCKED and RESET_N.
  task automatic measure_lock(input string tag);
    int unsigned lk_edge;
    int unsigned rn_edge;
    lk_edge = 0;
    rn_edge = 0;
    for (int unsigned i = 1; i <= 70; i++) begin
      tick();
      if (lk_edge == 0 && locked === 1'b1) lk_edge = i;
      if (rn_edge == 0 && reset_n === 1'b1) rn_edge = i;
    end
    check_eq({tag, ".locked_edge"},  lk_edge, SYNC + 1 + LF);
    check_eq({tag, ".reset_n_edge"}, rn_edge, SYNC + 1 + LF + RH);
  endtask

  initial begin
    int unsigned len;
    rst          = 1'b1;
    pll_locked   = 1'b0;
    clear_status = 1'b0;
    do_reset();
    ticks(5);

    // Clean lock
    pll_locked = 1'b1;
    measure_lock("clean");
    check_eq("clean.lock_lost", lock_lost, 0);

    // Glitch while filtering: no loss, latency restarts at the second rise
    do_reset();
    pll_locked = 1'b1;
    ticks(10);
    pll_locked = 1'b0;
    ticks(3);
    pll_locked = 1'b1;
    measure_lock("glitch");
    check_eq("glitch.loss_count", loss_count, 0);

    // Loss in RUN, then relock
    pll_locked = 1'b0;
    tick();
    check_eq("drop.locked_edge1", locked, 1);
    ticks(SYNC);
    check_eq("drop.locked", locked, 0);
    check_eq("drop.reset_n", reset_n, 0);
    check_eq("drop.lock_lost", lock_lost, 1);
    check_eq("drop.loss_count", loss_count, 1);
    ticks(3);
    pll_locked = 1'b1;
    measure_lock("relock");

    // Clear coincident with the second loss event, then clear alone
    pll_locked = 1'b0;
    ticks(SYNC);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check_eq("clr_vs_loss.loss_count", loss_count, 1);
    check_eq("clr_vs_loss.lock_lost", lock_lost, 1);
    clear_status = 1'b1;
    tick();
    clear_status = 1'b0;
    check_eq("clr_only.loss_count", loss_count, 0);
    check_eq("clr_only.lock_lost", lock_lost, 0);

    // Saturation: five losses (from HOLD) on a 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      pll_locked = 1'b1;
      ticks(LOCK_AT + SYNC + 4);
      pll_locked = 1'b0;
      ticks(SYNC + 3);
    end
    check_eq("sat.count2", loss_count2, 3);
    check_eq("sat.count8", loss_count, 5);

    // Async reset mid-HOLD, then mid-RUN; each followed by a full sequence
    do_reset();
    pll_locked = 1'b1;
    ticks(30);
    check_eq("mid_hold.locked", locked, 1);
    do_reset();
    measure_lock("after_hold_rst");
    do_reset();
    measure_lock("after_run_rst");

    // Randomized lock traffic with occasional clears and resets
    for (int s = 0; s < 100; s++) begin
      pll_locked = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 70);
      for (int unsigned i = 0; i < len; i++) begin
        clear_status = ($urandom_range(0, 15) == 0);
        tick();
      end
      clear_status = 1'b0;
      if ($urandom_range(0, 19) == 0) do_reset();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
